rom_burst_reader: RTL and testbench
===================================

ROM_BURST_READER -- requirements
Module: rom_burst_reader

Interface
REQ-001: Parameter ADDR_W, default 7, address width; depth is 2^ADDR_W words.
REQ-002: Parameter DATA_W, default 1, word width in bits.
REQ-003: Parameter INIT, default all-zero, flat (2^ADDR_W)*DATA_W-bit vector; word i = INIT[i*DATA_W +: DATA_W].
REQ-004: CLK  in  1  sole clock, all state on rising edge.
REQ-005: RESET  in  1  synchronous, active-high reset.
REQ-006: req_valid  in  1  burst request offered.
REQ-007: req_ready  out  1  request accepted when req_valid && req_ready.
REQ-008: req_addr  in  ADDR_W  start address.
REQ-009: req_len  in  ADDR_W  burst length minus one (0 = single word).
REQ-010: rsp_valid  out  1  rsp_data/rsp_last valid.
REQ-011: rsp_ready  in  1  consumer accepts word when rsp_valid && rsp_ready.
REQ-012: rsp_data  out  DATA_W  ROM word.
REQ-013: rsp_last  out  1  final word of a burst.
REQ-014: busy  out  1  burst issuing, read in flight, or output buffer non-empty.

Function
REQ-015: FSM states IDLE and RUN; req_ready = 1 only in IDLE.
REQ-016: IDLE -> RUN on accepted request; latch address = req_addr, remaining = req_len.
REQ-017: In RUN, issue one ROM read per cycle when credit permits; after each issue address increments modulo 2^ADDR_W and remaining decrements.
REQ-018: RUN -> IDLE in the cycle the read with remaining == 0 is issued; that read carries last = 1; a new request is acceptable in the following cycle while earlier words drain.
REQ-019: ROM read is registered: issued in cycle N, data enters output buffer at end of cycle N+1.
REQ-020: Output buffer is a 2-entry FIFO; rsp_valid = buffer non-empty; rsp_data/rsp_last driven from head.
REQ-021: Credit rule: issue only if (occupancy + in-flight - pop_this_cycle) < 2; buffer never overflows, no word dropped or duplicated.
REQ-022: With rsp_ready held high, request accepted in cycle N gives first rsp_valid in cycle N+2 and one word per cycle thereafter.
REQ-023: While rsp_valid && !rsp_ready, rsp_data and rsp_last hold stable.
REQ-024: Words leave in issue order across consecutive bursts.
REQ-025: Address wrap 2^ADDR_W-1 -> 0 is silent; req_len = 2^ADDR_W-1 reads every word once.
REQ-026: Push and pop in the same cycle on a full or empty buffer are legal and keep occupancy consistent.

Reset
REQ-027: RESET sampled high: FSM -> IDLE, in-flight read discarded, buffer emptied, address/remaining cleared.
REQ-028: Outputs in the cycle after reset: rsp_valid = 0, rsp_last = 0, rsp_data = 0, busy = 0, req_ready = 1.
REQ-029: Reset mid-burst aborts the burst; no stale word appears afterwards.
REQ-030: ROM contents are constant and unaffected by reset.

Structure
REQ-031: Shared package rom_pkg holds the state enum (IDLE, RUN) and the buffer-depth constant (2).
REQ-032: One sub-module, rom_out_fifo (2-entry, DATA_W+1 wide, synchronous reset); ROM array and FSM live in rom_burst_reader.
REQ-033: ROM array inferred from INIT so it maps to LUT or block RAM without vendor primitives.

Verification (ADDR_W=7, DATA_W=1, INIT word i = i[0])
REQ-034: Single: req_addr=5, req_len=0, rsp_ready=1 -> rsp_valid at accept+2, rsp_data=1, rsp_last=1, busy falls next cycle.
REQ-035: Burst: req_addr=0, req_len=7 -> 8 consecutive words 0,1,0,1,0,1,0,1, rsp_last only on 8th.
REQ-036: Wrap: req_addr=126, req_len=3 -> addresses 126,127,0,1, data 0,1,0,1.
REQ-037: Backpressure: burst addr 0 len 15, rsp_ready low 5 cycles mid-burst -> exactly 16 words in order, data stable while stalled, occupancy never above 2.
REQ-038: Back-to-back: second request (addr 3, len 1) held valid -> accepted cycle after first burst's last issue; output 1 then 0 follows first burst with no gap.
REQ-039: Reset mid-burst (after 3 words) -> next cycle rsp_valid=0, busy=0, req_ready=1; subsequent single read at addr 2 returns 0.

Source files
------------

// File: rtl/rom_pkg.sv
// Shared types and constants for the ROM burst reader: FSM states, output buffer depth,
// and the credit test that keeps the output buffer from overflowing.
package rom_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = 2;

  // A read may issue only if every word already committed still fits after this cycle's pop.
  function automatic logic credit_ok(input logic [CNT_W-1:0] occ,
                                     input logic             inflight,
                                     input logic             pop);
    logic [CNT_W:0] load;
    load = {1'b0, occ} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
    return load < (CNT_W+1)'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/rom_burst_reader_if.sv
// Burst request / word response handshake bundle for the ROM burst reader.
// The master issues requests and consumes words; the slave is the reader.
interface rom_burst_reader_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 1
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_len;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;

  modport master (
    output req_valid, req_addr, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_last
  );

  modport slave (
    input  req_valid, req_addr, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_last
  );

endinterface

// File: rtl/rom_out_fifo.sv
// Two-entry output buffer: push lands at end of cycle, head visible the next cycle.
// Simultaneous push and pop are legal at any occupancy; a pop on empty is ignored.
module rom_out_fifo
  import rom_pkg::*;
#(
  parameter int W = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             push,
  input  logic [W-1:0]     push_dat,
  input  logic             pop,
  output logic [W-1:0]     head_dat,
  output logic [CNT_W-1:0] count,
  output logic             vld
);

  logic [W-1:0] mem [BUF_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(BUF_DEPTH)) || do_pop);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign head_dat = mem[rd_ptr];
  assign vld      = (count != '0);

endmodule

// File: rtl/rom_burst_reader.sv
// Streams bursts of ROM words through a 2-entry buffer; first word two cycles after accept.
// Reads issue only with buffer credit, so rsp_ready backpressure stalls issue without loss.
module rom_burst_reader
  import rom_pkg::*;
#(
  parameter int                                ADDR_W = 7,
  parameter int                                DATA_W = 1,
  parameter logic [(2**ADDR_W)*DATA_W-1:0]     INIT   = '0
) (
  input  logic               CLK,
  input  logic               RESET,
  rom_burst_reader_if.slave  bus,
  output logic               busy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] rom [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign rom[i] = INIT[i*DATA_W +: DATA_W];
  end

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, addr_n, rem, rem_n;
  logic [ADDR_W-1:0] iss_addr, iss_rem;
  logic              accept, issue, pop;
  logic              rd_vld, rd_last;
  logic [DATA_W-1:0] rd_dat;
  logic [CNT_W-1:0]  count;
  logic [DATA_W:0]   head;
  logic              fifo_vld;

  assign bus.req_ready = (state == IDLE);
  assign accept        = bus.req_valid && bus.req_ready;
  assign pop           = bus.rsp_valid && bus.rsp_ready;

  // The accept cycle already issues the first read, so bursts chain without a bubble.
  always_comb begin
    state_n  = state;
    addr_n   = addr;
    rem_n    = rem;
    iss_addr = (state == IDLE) ? bus.req_addr : addr;
    iss_rem  = (state == IDLE) ? bus.req_len  : rem;
    issue    = (accept || (state == RUN)) && credit_ok(count, rd_vld, pop);
    if (issue) begin
      addr_n  = iss_addr + ADDR_W'(1);
      rem_n   = iss_rem - ADDR_W'(1);
      state_n = (iss_rem == '0) ? IDLE : RUN;
    end else if (accept) begin
      addr_n  = bus.req_addr;
      rem_n   = bus.req_len;
      state_n = RUN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      addr    <= '0;
      rem     <= '0;
      rd_vld  <= 1'b0;
      rd_last <= 1'b0;
      rd_dat  <= '0;
    end else begin
      state   <= state_n;
      addr    <= addr_n;
      rem     <= rem_n;
      rd_vld  <= issue;
      if (issue) begin
        rd_dat  <= rom[iss_addr];
        rd_last <= (iss_rem == '0);
      end
    end
  end

  rom_out_fifo #(.W(DATA_W + 1)) u_fifo (
    .CLK      (CLK),
    .RESET    (RESET),
    .push     (rd_vld),
    .push_dat ({rd_last, rd_dat}),
    .pop      (pop),
    .head_dat (head),
    .count    (count),
    .vld      (fifo_vld)
  );

  assign bus.rsp_valid                  = fifo_vld;
  assign {bus.rsp_last, bus.rsp_data}   = head;
  assign busy = (state == RUN) || rd_vld || (count != '0);

endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: directed burst table, multi-cycle corner sequences,
// and randomized traffic checked against a queue-based model of the expected word stream.
module tb_rom_burst_reader;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 1;
  localparam int DEPTH  = 128;
  localparam logic [DEPTH*DATA_W-1:0] INIT = {64{2'b10}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  rom_burst_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rom_burst_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT(INIT)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    int          len;
    int          n;
    logic [15:0] bits;
  } vec_t;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         acc_cyc  = 0;
  logic       acc_flag = 1'b0;
  logic       stalled  = 1'b0;
  logic [1:0] prev_word = 2'b00;
  logic [1:0] exp_q [$];
  logic [1:0] got_q [$];
  int         got_cyc [$];

  // Word at address a of a ROM whose word i is bit 0 of i.
  function automatic logic ref_word(input int a);
    int w;
    w = (a % DEPTH) % 2;
    return w[0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // One clock: sample handshakes mid-cycle, update the model, then advance past the edge.
  task automatic tick();
    logic       acc, pp;
    logic [1:0] w;
    int         a, l;
    @(negedge clk);
    acc = bus.req_valid && bus.req_ready;
    pp  = bus.rsp_valid && bus.rsp_ready;
    w   = {bus.rsp_last, bus.rsp_data};
    a   = int'(bus.req_addr);
    l   = int'(bus.req_len);
    if (!rst) begin
      if (stalled) begin
        chk("hold_valid", bus.rsp_valid, 1);
        chk("hold_word", w, prev_word);
      end
      stalled   = bus.rsp_valid && !bus.rsp_ready;
      prev_word = w;
      if (pp) begin
        if (exp_q.size() == 0) note_fail("unexpected_word");
        else chk("stream_word", w, exp_q.pop_front());
        got_q.push_back(w);
        got_cyc.push_back(cyc);
      end
      if (acc) begin
        for (int k = 0; k <= l; k++) exp_q.push_back({k == l, ref_word(a + k)});
        acc_cyc  = cyc;
        acc_flag = 1'b1;
      end
    end else begin
      stalled = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_accept(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      acc_flag = 1'b0;
      tick();
      if (acc_flag) begin
        ok = 1;
        break;
      end
    end
    if (!ok) note_fail(name);
  endtask

  task automatic wait_words(input int n, input int budget);
    for (int i = 0; i < budget && got_q.size() < n; i++) tick();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_last"}, bus.rsp_last, 0);
    chk({tag, "_rsp_data"}, bus.rsp_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req_ready"}, bus.req_ready, 1);
  endtask

  task automatic run_burst(input string tag, input vec_t v);
    logic [15:0] gb, gl;
    got_q.delete();
    got_cyc.delete();
    bus.rsp_ready = 1'b1;
    bus.req_addr  = 7'(v.addr);
    bus.req_len   = 7'(v.len);
    bus.req_valid = 1'b1;
    wait_accept({tag, "_accept"});
    bus.req_valid = 1'b0;
    wait_words(v.n, 40);
    chk({tag, "_count"}, got_q.size(), v.n);
    if (got_q.size() >= v.n) begin
      gb = '0;
      gl = '0;
      for (int i = 0; i < v.n; i++) begin
        gb[i] = got_q[i][0];
        gl[i] = got_q[i][1];
      end
      chk({tag, "_latency"}, got_cyc[0] - acc_cyc, 2);
      chk({tag, "_gapless"}, got_cyc[v.n-1] - got_cyc[0], v.n - 1);
      chk({tag, "_data"}, gb, v.bits);
      chk({tag, "_last"}, gl, 16'(1) << (v.n - 1));
      chk({tag, "_busy_after"}, busy, 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  vec_t tbl [6];

  initial begin
    int          bursts;
    int          a1, a2, nlast;
    logic [15:0] gb, gl;

    tbl[0] = '{addr: 5,   len: 0,  n: 1,  bits: 16'h0001};
    tbl[1] = '{addr: 0,   len: 7,  n: 8,  bits: 16'h00AA};
    tbl[2] = '{addr: 126, len: 3,  n: 4,  bits: 16'h000A};
    tbl[3] = '{addr: 3,   len: 2,  n: 3,  bits: 16'h0005};
    tbl[4] = '{addr: 127, len: 0,  n: 1,  bits: 16'h0001};
    tbl[5] = '{addr: 64,  len: 15, n: 16, bits: 16'hAAAA};

    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    chk_idle_outputs("reset");

    for (int i = 0; i < 6; i++) run_burst($sformatf("tbl%0d", i), tbl[i]);

    // Backpressure mid-burst.
    got_q.delete();
    got_cyc.delete();
    bus.rsp_ready = 1'b1;
    bus.req_addr  = 7'd0;
    bus.req_len   = 7'd15;
    bus.req_valid = 1'b1;
    wait_accept("bp_accept");
    bus.req_valid = 1'b0;
    wait_words(4, 20);
    bus.rsp_ready = 1'b0;
    repeat (5) tick();
    chk("bp_stalled_valid", bus.rsp_valid, 1);
    bus.rsp_ready = 1'b1;
    wait_words(16, 60);
    repeat (3) tick();
    chk("bp_count", got_q.size(), 16);
    if (got_q.size() == 16) begin
      gb = '0;
      gl = '0;
      for (int i = 0; i < 16; i++) begin
        gb[i] = got_q[i][0];
        gl[i] = got_q[i][1];
      end
      chk("bp_data", gb, 16'hAAAA);
      chk("bp_last", gl, 16'h8000);
    end
    chk("bp_busy_after", busy, 0);

    // Back-to-back: second request held valid while the first burst runs.
    got_q.delete();
    got_cyc.delete();
    bus.req_addr  = 7'd0;
    bus.req_len   = 7'd7;
    bus.req_valid = 1'b1;
    wait_accept("b2b_accept1");
    a1 = acc_cyc;
    bus.req_addr = 7'd3;
    bus.req_len  = 7'd1;
    wait_accept("b2b_accept2");
    a2 = acc_cyc;
    bus.req_valid = 1'b0;
    wait_words(10, 40);
    chk("b2b_accept_gap", a2 - a1, 8);
    chk("b2b_count", got_q.size(), 10);
    if (got_q.size() >= 10) begin
      chk("b2b_span", got_cyc[9] - got_cyc[0], 9);
      chk("b2b_first_last", got_q[7], 2'b11);
      chk("b2b_tail", {got_q[8], got_q[9]}, 4'b0110);
    end

    // Full-depth read wrapping past the top address.
    got_q.delete();
    got_cyc.delete();
    bus.req_addr  = 7'd10;
    bus.req_len   = 7'd127;
    bus.req_valid = 1'b1;
    wait_accept("full_accept");
    bus.req_valid = 1'b0;
    wait_words(128, 200);
    repeat (3) tick();
    chk("full_count", got_q.size(), 128);
    nlast = 0;
    foreach (got_q[i]) nlast += int'(got_q[i][1]);
    chk("full_last_count", nlast, 1);

    // Reset mid-burst after three words.
    got_q.delete();
    got_cyc.delete();
    bus.req_addr  = 7'd0;
    bus.req_len   = 7'd15;
    bus.req_valid = 1'b1;
    wait_accept("rst_accept");
    bus.req_valid = 1'b0;
    wait_words(3, 20);
    do_reset();
    chk_idle_outputs("midrst");
    run_burst("post_rst", '{addr: 2, len: 0, n: 1, bits: 16'h0000});
    repeat (5) tick();
    chk("post_rst_no_stale", got_q.size(), 1);

    // Randomized traffic against the model.
    bursts = 0;
    for (int c = 0; c < 4000 && bursts < 40; c++) begin
      if (!bus.req_valid && ($urandom_range(0, 2) == 0)) begin
        bus.req_valid = 1'b1;
        bus.req_addr  = 7'($urandom);
        bus.req_len   = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'($urandom_range(0, 12));
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      acc_flag = 1'b0;
      tick();
      if (acc_flag) begin
        bus.req_valid = 1'b0;
        bursts++;
      end
    end
    chk("rand_bursts", bursts, 40);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 400 && (exp_q.size() != 0 || busy); i++) tick();
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_busy_end", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
